// File: rtl/fact_bcd_conv.sv
// fact_bcd_conv: sequential double-dabble converter from binary to packed BCD.
// One iteration per clock, with a valid/ready handshake on both sides.
module fact_bcd_conv #(
   parameter int WIDTH  = 13,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]    acc_q, acc_d;
   logic [BW-1:0]    adj;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   // Add-3 correction of every digit that would overflow past 9 once doubled.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_data;
               acc_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // {acc, sr} << 1 after the correction step.
            acc_d = {adj[BW-2:0], sr_q[WIDTH-1]};
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = {adj[BW-2:0], sr_q[WIDTH-1]};
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == SHIFT);
   end

   // State and output registers; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_bcd   = bcd_q;
endmodule

// File: tb/tb_fact_bcd_conv.sv
// Directed bench for fact_bcd_conv with hand-computed BCD results.
module tb_fact_bcd_conv;
   logic        clk = 0;
   logic        rst = 1;
   logic        in_valid = 0;
   logic [12:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1;
   logic [15:0] out_bcd;
   logic        busy;

   int errs = 0;
   int checks = 0;

   fact_bcd_conv #(.WIDTH(13), .DIGITS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_bcd(out_bcd), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Send one value, check latency/busy, optionally stall, then check return to IDLE.
   task automatic run(input logic [12:0] val, input logic [15:0] exp, input int stall, input bit noise);
      int n, nb, w;
      bit bad;
      out_ready = (stall == 0);
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      chk("accept_wait", 32'(w < 50), 1);
      in_valid = 1; in_data = val;
      tick();                       // accept edge
      in_valid = 0;
      chk("acc_busy", 32'(busy), 1);
      chk("acc_rdy", 32'(in_ready), 0);
      n = 0; nb = 0;
      while (!out_valid && n < 40) begin
         if (busy) nb++;
         if (noise) begin in_data = 13'($urandom); in_valid = 1'($urandom); end
         tick(); n++;
      end
      in_valid = 0;
      chk("latency", 32'(n), 13);
      chk("busy_cycles", 32'(nb), 13);
      chk("result", 32'(out_bcd), 32'(exp));
      chk("done_busy", 32'(busy), 0);
      bad = 0;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (!(out_valid && out_bcd == exp && !in_ready && !busy)) bad = 1;
      end
      if (stall > 0) chk("stall_hold", 32'(bad), 0);
      out_ready = 1;
      tick();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_ready", 32'(in_ready), 1);
      chk("idle_keep", 32'(out_bcd), 32'(exp));
   endtask

   logic [12:0] fin [7] = '{13'd1, 13'd2, 13'd6, 13'd24, 13'd120, 13'd720, 13'd5040};
   logic [15:0] fex [7] = '{16'h0001, 16'h0002, 16'h0006, 16'h0024, 16'h0120, 16'h0720, 16'h5040};

   initial begin
      int k, sent, last, cyc, n;
      bit seen;
      // reset
      rst = 1; tick(); tick(); rst = 0;
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bcd", 32'(out_bcd), 0);

      run(13'd5040, 16'h5040, 0, 0);
      run(13'd0,    16'h0000, 0, 0);
      run(13'd8191, 16'h8191, 0, 0);
      run(13'd720,  16'h0720, 20, 0);
      run(13'd120,  16'h0120, 0, 1);

      // reset at SHIFT iteration 6
      in_valid = 1; in_data = 13'd5040; tick(); in_valid = 0;
      repeat (5) tick();
      chk("mid_busy", 32'(busy), 1);
      rst = 1; tick(); rst = 0;
      chk("abort_ready", 32'(in_ready), 1);
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_bcd", 32'(out_bcd), 0);
      chk("abort_busy", 32'(busy), 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid) seen = 1; end
      chk("abort_noval", 32'(seen), 0);
      run(13'd24, 16'h0024, 0, 0);

      // stream factorials back-to-back
      out_ready = 1; k = 0; sent = 0; last = 0; cyc = 0;
      in_valid = 1; in_data = fin[0];
      while (k < 7 && cyc < 300) begin
         if (in_ready && in_valid) begin
            tick(); cyc++; sent++;
            if (sent < 7) in_data = fin[sent]; else in_valid = 0;
         end else begin
            tick(); cyc++;
         end
         if (out_valid) begin
            chk("stream_val", 32'(out_bcd), 32'(fex[k]));
            if (k > 0) chk("stream_gap", 32'(cyc - last), 15);
            last = cyc; k++;
         end
      end
      in_valid = 0;
      chk("stream_count", 32'(k), 7);
      n = 0;
      while (!in_ready && n < 5) begin tick(); n++; end
      chk("stream_idle", 32'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/fact_bcd_conv.md
FACT_BCD_CONV -- requirements
Module: fact_bcd_conv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, giving the binary input width; it matches the factorial result width of 7! = 5040.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the BCD output digit count; it SHALL satisfy 10**DIGITS > 2**WIDTH - 1.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the upstream factorial result on in_data is valid.
REQ-006 Port in_data, input, WIDTH bits: unsigned binary value to convert.
REQ-007 Port in_ready, output, 1 bit: the block can accept a new value.
REQ-008 Port out_valid, output, 1 bit: out_bcd holds a completed conversion.
REQ-009 Port out_ready, input, 1 bit: the downstream consumer (7-seg driver) accepts out_bcd.
REQ-010 Port out_bcd, output, 4*DIGITS bits: packed BCD result, with the most significant digit in the top nibble.
REQ-011 Port busy, output, 1 bit: a conversion is in progress (SHIFT state).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL equal 1 in IDLE only, registered and decoded from state, with no combinational path from any input.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; on that edge the block latches in_data into a WIDTH-bit shift register, clears the BCD accumulator, loads the iteration counter with WIDTH, and enters SHIFT.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration in a single clock: add 3 to every BCD digit >= 5, then shift {accumulator, shift register} left by 1, then decrement the counter.
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-017 out_valid SHALL be 1 in DONE only, so it first becomes visible WIDTH edges after the input-transfer edge.
REQ-018 In DONE, out_bcd SHALL hold stable until an edge where out_ready is 1; on that edge the FSM enters IDLE.
REQ-019 out_ready=0 SHALL stall the block in DONE indefinitely with no data loss.
REQ-020 The block SHALL provide no bypass: in_ready rises on the cycle after the output transfer, so with out_ready tied high the sustained rate is one conversion per WIDTH+2 cycles.
REQ-021 in_valid and in_data SHALL be ignored outside IDLE; in_data changes during SHIFT or DONE SHALL not affect the result.
REQ-022 out_bcd SHALL retain the last result in IDLE and SHIFT; only the DONE entry edge updates the visible output register.
REQ-023 Input 0 SHALL yield 0x0000, with the full WIDTH-cycle latency and no early exit.
REQ-024 Input 2**WIDTH-1 (8191) SHALL yield 0x8191, and no digit SHALL ever exceed 9.
REQ-025 busy SHALL equal 1 exactly in SHIFT.

Reset
REQ-026 On an edge with rst=1, the block SHALL enter IDLE and set out_valid=0, busy=0, out_bcd=0, counter=0 and shift register=0; in_ready SHALL be 1 from the following cycle.
REQ-027 rst SHALL take priority over all handshakes; a reset in SHIFT or DONE SHALL abort the conversion without emitting out_valid.
REQ-028 No output SHALL be X after the first reset edge.

Verification
REQ-029 Scenario: after reset, send 5040 with out_ready=1 -> in_ready drops, busy=1 for 13 cycles, out_valid=1 with out_bcd=0x5040 on the 13th cycle after the accept, then returns to IDLE.
REQ-030 Scenario: send 0, then 8191 -> out_bcd=0x0000, then out_bcd=0x8191, each with 13-cycle latency.
REQ-031 Scenario: stream the factorials 1, 2, 6, 24, 120, 720, 5040 with in_valid held high and out_ready=1 -> outputs 0x0001, 0x0002, 0x0006, 0x0024, 0x0120, 0x0720, 0x5040, in order, one every 15 cycles.
REQ-032 Scenario: send 720 with out_ready=0 for 20 cycles after out_valid -> out_valid and 0x0720 held stable, in_ready=0 throughout; out_ready=1 -> one transfer, then in_ready=1.
REQ-033 Scenario: assert rst for 1 cycle at SHIFT iteration 6 of input 5040 -> no out_valid, in_ready=1 next cycle, out_bcd=0x0000; a following input 24 yields 0x0024.
REQ-034 Scenario: toggle in_data randomly during SHIFT for input 120 -> result is still 0x0120.
